// File: rtl/trace_pkg.sv
// Shared types and constants for the writeback trace checker.
package trace_pkg;

  localparam int TRACE_ENTRY_WD = 69;
  localparam int TRACE_WDATA_LSB = 0;
  localparam int TRACE_WNUM_LSB  = 32;
  localparam int TRACE_PC_LSB    = 37;

  // Packed MSB-first: pc[68:37], wnum[36:32], wdata[31:0]
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous golden-trace FIFO; head is visible one cycle after the push (no bypass).
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/trace_checker.sv
// Compares CPU writeback commits against buffered golden entries; latches the first failure.
// Define TRACE_BYTE_MASK_EN to restrict the wdata compare to bytes whose wen bit is set.
//
// state | meaning
// RUN   | comparing each qualifying commit against the FIFO head
// HALT  | first failure captured; compares, pops and counting frozen until reset
module trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gold_valid,
  output logic                       gold_ready,
  input  logic [31:0]                gold_pc,
  input  logic [4:0]                 gold_wnum,
  input  logic [31:0]                gold_wdata,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_wen,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic                       err,
  output logic                       underflow,
  output logic [31:0]                err_pc,
  output logic [31:0]                err_exp_wdata,
  output logic [31:0]                err_got_wdata
);

  trace_state_t state, next_state;
  trace_entry_t gold_entry;
  trace_entry_t head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         commit_q;
  logic         wdata_eq;
  logic         head_match;
  logic         cnt_inc;
  logic         capture;
  logic         cap_underflow;

  assign gold_ready = !full;
  assign push       = gold_valid && !full;
  assign gold_entry = '{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_ENTRY_WD)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (gold_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign commit_q = (debug_wb_rf_wen != 4'b0) && (debug_wb_rf_wnum != 5'd0);

`ifdef TRACE_BYTE_MASK_EN
  logic [31:0] wdata_mask;
  assign wdata_mask = {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}},
                       {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};
  assign wdata_eq   = ((head.wdata ^ debug_wb_rf_wdata) & wdata_mask) == 32'd0;
`else
  assign wdata_eq   = (head.wdata == debug_wb_rf_wdata);
`endif

  assign head_match = (head.pc == debug_wb_pc) && (head.wnum == debug_wb_rf_wnum) && wdata_eq;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    cnt_inc       = 1'b0;
    capture       = 1'b0;
    cap_underflow = 1'b0;
    unique case (state)
      RUN: begin
        if (commit_q) begin
          if (empty) begin
            capture       = 1'b1;
            cap_underflow = 1'b1;
            next_state    = HALT;
          end else if (head_match) begin
            pop     = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            // A mismatching entry is consumed so the FIFO reflects what was checked.
            pop        = 1'b1;
            capture    = 1'b1;
            next_state = HALT;
          end
        end
      end
      HALT: next_state = HALT;
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_cnt      <= '0;
      err           <= 1'b0;
      underflow     <= 1'b0;
      err_pc        <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
    end else begin
      if (cnt_inc && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
      // capture only fires from RUN, so only the first failure is ever recorded
      if (capture) begin
        err           <= 1'b1;
        underflow     <= cap_underflow;
        err_pc        <= debug_wb_pc;
        err_exp_wdata <= cap_underflow ? 32'd0 : head.wdata;
        err_got_wdata <= debug_wb_rf_wdata;
      end
    end
  end

endmodule

// File: doc/trace_checker.md
# trace_checker

Consumer of the CPU's writeback trace interface (debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata). It buffers golden trace entries pushed by a reference source and compares every qualifying register-file commit against the FIFO head. It counts passes and latches the first mismatch or underflow for debug. It sits beside the CPU top in the SoC/verification shell, at the receiving end of the trace debug interface.

## Interface
Parameters:
- DEPTH, 8: golden FIFO depth; power of two, ≥2.
- CNT_W, 16: width of pass counter.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- gold_valid  in  1  golden entry offered.
- gold_ready  out  1  FIFO can accept; equals !full.
- gold_pc  in  32  expected PC.
- gold_wnum  in  5  expected destination register.
- gold_wdata  in  32  expected write data.
- debug_wb_pc  in  32  commit PC from the CPU.
- debug_wb_rf_wen  in  4  commit byte write enables.
- debug_wb_rf_wnum  in  5  commit destination register.
- debug_wb_rf_wdata  in  32  commit write data.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- pass_cnt  out  CNT_W  matched commits; saturates at all-ones.
- err  out  1  sticky mismatch flag.
- underflow  out  1  sticky: qualifying commit arrived with FIFO empty.
- err_pc  out  32  PC of the first failing commit.
- err_exp_wdata  out  32  golden wdata at the first failure (0 on underflow).
- err_got_wdata  out  32  committed wdata at the first failure.

## Operation
- Push: gold_valid && gold_ready writes {pc, wnum, wdata} at the tail.
- Qualifying commit (q): debug_wb_rf_wen != 0 && debug_wb_rf_wnum != 0. Writes to r0 and no-write cycles are ignored.
- State RUN:
  - q && empty: underflow <= 1, err <= 1, capture err_pc/err_got_wdata, err_exp_wdata <= 0, go to HALT.
  - q && head match (pc, wnum, wdata all equal): pop, pass_cnt += 1 (saturating).
  - q && head mismatch: err <= 1, capture err_pc, err_exp_wdata = head wdata, err_got_wdata; pop; go to HALT.
- State HALT: no compares, no pops, no counter changes. Pushes still accepted while not full. Only reset exits HALT.
- Only the first failure is captured. Later commits never overwrite err_* fields.
- Push and pop in the same cycle: fifo_count is unchanged; pointers wrap modulo DEPTH.
- No bypass: an entry pushed in cycle N is visible at the head in cycle N+1. A commit in cycle N against an empty FIFO is an underflow, even if a push occurs in cycle N.
- Full: gold_ready=0. A simultaneous pop does not raise gold_ready in the same cycle.

## Timing
- Compare is combinational against the FIFO head in the commit cycle. pass_cnt, err, underflow, err_* and state update on the next clk edge (1-cycle latency).
- fifo_count reflects pushes and pops on the next edge.
- Reset (any cycle, including mid-HALT): state=RUN, pointers=0, fifo_count=0, gold_ready=1, pass_cnt=0, err=0, underflow=0, err_pc=err_exp_wdata=err_got_wdata=0. The FIFO contents are discarded.
- Back-to-back commits every cycle are supported; throughput is one compare per cycle.

## Configuration
- TRACE_BYTE_MASK_EN defined: the wdata compare covers only the bytes whose debug_wb_rf_wen bit is set. Masked-off bytes are ignored. err_got_wdata and err_exp_wdata still report the full 32 bits.
- Not defined: the full 32-bit wdata compare applies whenever q holds, regardless of which wen bits are set.

## Structure
- Package trace_pkg holds:
  - TRACE_ENTRY_WD = 69 (32+5+32) and field offset constants.
  - Entry struct typedef {pc, wnum, wdata}.
  - State enum {RUN, HALT}.
- Sub-module trace_fifo: synchronous FIFO, parameterised by DEPTH and entry width. Ports: push, pop, din, dout (head), full, empty, count.
- trace_checker holds the compare logic, the FSM, the counters and the capture registers.

## Test plan
- Push 3 entries (pc 0x1c000000/04/08, wnum 1/2/3, wdata 1/2/3), then 3 matching commits on consecutive cycles -> pass_cnt=3, fifo_count=0, err=0.
- Push 1 entry (pc 0x1c000000, wnum 4, wdata 0x5); commit with wdata 0x6 -> err=1, err_pc=0x1c000000, err_exp_wdata=5, err_got_wdata=6. A subsequent matching commit leaves pass_cnt=0.
- Empty FIFO; commit wen=0xf, wnum=5 -> underflow=1, err=1, err_exp_wdata=0. A commit with wnum=0 or wen=0 on an empty FIFO -> no flag.
- Fill to DEPTH (8) -> gold_ready=0. Push attempt ignored; simultaneous matching commit -> fifo_count=7 next cycle, gold_ready=1.
- wen=0x1, wdata 0xAABB0011 vs golden 0x00000011 -> pass with TRACE_BYTE_MASK_EN, err without it.
- Assert reset while in HALT with fifo_count=4 -> all outputs at reset values next cycle; a fresh push+commit passes.
